// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes, select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN adds the TRAP state.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
`else
        S_JAL      = 4'd10
`endif
    } mc_state_t;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/mc_imm_src_dec.sv
// Opcode to immediate-format decoder, shared by the multicycle and pipelined controllers.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows opcode every cycle.
// Ports: opcode (in, 7) -> imm_src (out, 3).
module mc_imm_src_dec
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OP_LOAD, OP_IMM: imm_src = IMM_I;
            OP_STORE:        imm_src = IMM_S;
            OP_BRANCH:       imm_src = IMM_B;
            OP_JAL:          imm_src = IMM_J;
            default:         imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles; outputs are decoded from the current state.
// Backpressure: mem_req held in FETCH/MEMREAD/MEMWRITE until mem_ready; each low cycle adds one cycle.
// Ports: clk, rst_n (async active-low); opcode, zero, mem_ready in; memory strobes, datapath
// selects, alu_op_type, imm_src out; illegal_instr out only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
module mc_main_ctrl
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op_type,
    output logic [2:0] imm_src
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_instr
`endif
);

    mc_state_t  state_q;
    mc_state_t  state_nxt;
    logic [2:0] imm_src_dec;

    mc_imm_src_dec u_imm_src_dec (
        .opcode  (opcode),
        .imm_src (imm_src_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_op_type = ALU_ADD;
        imm_src     = imm_src_dec;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed on the live ALU result so PC updates with the IR load.
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form OldPC+imm so BEQ/JAL find their target in ALUOut.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_R:              state_nxt = S_EXECR;
                    OP_IMM:            state_nxt = S_EXECI;
                    OP_BRANCH:         state_nxt = S_BEQ;
                    OP_JAL:            state_nxt = S_JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:           state_nxt = S_TRAP;
`else
                    default:           state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                // opcode[5] separates store (0100011) from load (0000011)
                state_nxt = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_op_type = ALU_FUNCT;
                state_nxt   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_op_type = ALU_FUNCT;
                state_nxt   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BEQ: begin
                // ALUOut still holds the target computed in DECODE; the ALU compares rs1/rs2.
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_op_type = ALU_SUB;
                result_src  = RES_ALUOUT;
                pc_write    = zero;
                state_nxt   = S_FETCH;
            end
            S_JAL: begin
                // PC <- target from ALUOut while the ALU forms the link value OldPC+4.
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                alu_op_type = ALU_ADD;
                result_src  = RES_ALUOUT;
                pc_write    = 1'b1;
                state_nxt   = S_ALUWB;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                // Parked until reset; flag stays high for the whole stay.
                illegal_instr = 1'b1;
                state_nxt     = S_TRAP;
            end
`endif
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        // State is FETCH during reset, so its Moore outputs must be masked explicitly.
        if (!rst_n) begin
            mem_req     = 1'b0;
            mem_write   = 1'b0;
            adr_src     = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            reg_write   = 1'b0;
            result_src  = 2'b00;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            alu_op_type = 2'b00;
            imm_src     = 3'b000;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            illegal_instr = 1'b0;
`endif
        end
    end

endmodule

// File: doc/mc_main_ctrl.md
# mc_main_ctrl

Main control FSM for the multicycle RV32I core. Sequences one instruction at a time through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath mux selects, the register, IR, PC and memory strobes, and the 2-bit `alu_op_type` consumed by the ALU decoder. Sits beside the shared datapath (single ALU, single unified memory port) and handshakes with memory through `mem_req`/`mem_ready`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `opcode`  in  7  `instr[6:0]` from the IR.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory access request.
- `mem_write`  out  1  request is a store; valid only with `mem_req`.
- `adr_src`  out  1  0=PC, 1=ALUOut.
- `ir_write`  out  1  load IR and OldPC.
- `pc_write`  out  1  load PC from the result bus.
- `reg_write`  out  1  register file write enable.
- `result_src`  out  2  00=ALUOut, 01=read data, 10=ALU result.
- `alu_src_a`  out  2  00=PC, 01=OldPC, 10=rs1.
- `alu_src_b`  out  2  00=rs2, 01=imm, 10=constant 4.
- `alu_op_type`  out  2  00=ADD, 01=SUB, 10=funct-decoded.
- `imm_src`  out  3  000=I, 001=S, 010=B, 011=J.
- `illegal_instr`  out  1  sticky illegal-opcode flag. Present only with the macro.

## Operation
- Reset: the state goes to FETCH. While `rst_n`=0, all strobes (`mem_req`, `mem_write`, `ir_write`, `pc_write`, `reg_write`) are 0, all selects are 0, and `illegal_instr`=0.
- Outputs are decoded from the state. Two signals are Mealy-qualified: `ir_write`/`pc_write` in FETCH by `mem_ready`, and `pc_write` in BEQ by `zero`.
- `imm_src` is decoded combinationally from `opcode` in every state.
  - lw and OP-IMM → 000. sw → 001. beq → 010. jal → 011. Anything else → 000.
- Unlisted selects are 00 in each state below.

State behaviour and transitions:
- FETCH: `mem_req`=1, `adr_src`=0, src_a=PC, src_b=4, ADD, `result_src`=10.
  - If `mem_ready`: `ir_write`=1, `pc_write`=1, go to DECODE.
  - Otherwise stay in FETCH with no strobes.
- DECODE: src_a=OldPC, src_b=imm, ADD (branch/jump target into ALUOut). Branch on opcode:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - Other → see Configuration.
- MEMADR: src_a=rs1, src_b=imm, ADD. Go to MEMREAD if `opcode[5]`=0, else MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1. Stay until `mem_ready`, then go to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Go to FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1. Stay until `mem_ready`, then go to FETCH.
- EXECR: src_a=rs1, src_b=rs2, `alu_op_type`=10. Go to ALUWB.
- EXECI: src_a=rs1, src_b=imm, `alu_op_type`=10. Go to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1. Go to FETCH.
- BEQ: src_a=rs1, src_b=rs2, SUB, `result_src`=00, `pc_write`=`zero`. Go to FETCH.
- JAL: src_a=OldPC, src_b=4, ADD, `result_src`=00, `pc_write`=1. Go to ALUWB.
- At most one of `reg_write`/`mem_write`/`ir_write` is high in any cycle.

## Timing
- Minimum cycles per instruction, with `mem_ready` high on first assertion: lw 5, sw 4, R 4, I 4, beq 3, jal 4.
- Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- `mem_req` stays asserted, with the same address select, until `mem_ready` is seen.
- `mem_ready` outside those three states is ignored.
- Async reset mid-instruction aborts immediately. No strobe is issued in the reset cycle. First FETCH occurs on the first edge after deassertion.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - An unlisted opcode in DECODE goes to TRAP.
  - TRAP holds all strobes at 0 and sets `illegal_instr`=1.
  - TRAP is exited only by reset.
- Not defined:
  - An unlisted opcode in DECODE returns to FETCH, so the instruction acts as a 2-cycle NOP.
  - TRAP and `illegal_instr` are absent.

## Structure
- `riscv_pkg` holds the shared encodings:
  - the state enum `mc_state_t`;
  - the opcode constants (`OP_LOAD`, `OP_STORE`, `OP_R`, `OP_IMM`, `OP_BRANCH`, `OP_JAL`);
  - the select encodings (`RES_*`, `SRCA_*`, `SRCB_*`, `IMM_*`);
  - the `alu_op_type` constants.
- Sub-module `mc_imm_src_dec`: combinational opcode→`imm_src`, reused by the pipelined variant.

## Test plan
- Reset and fetch stall: hold `rst_n`=0 → all outputs 0. Release with `mem_ready`=0 for 3 cycles → FETCH held, `mem_req`=1, `ir_write`=0. Then `mem_ready`=1 → `ir_write`=`pc_write`=1 in that cycle.
- lw (0000011) with MEMREAD `mem_ready` delayed 2 cycles → total 7 cycles. `reg_write` with `result_src`=01 in exactly one cycle.
- sw (0100011) → `mem_write`=1 with `adr_src`=1 until `mem_ready`. `reg_write` never asserted. 4 cycles.
- beq with `zero`=1 → `pc_write`=1 in BEQ. With `zero`=0 → `pc_write`=0. Both take 3 cycles. `alu_op_type`=01 in BEQ.
- R-type (0110011) then jal (1101111):
  - R-type: `alu_op_type`=10 in EXECR.
  - jal: `pc_write` in JAL, then `reg_write` in ALUWB.
- Opcode 0000000 → with the macro, TRAP and `illegal_instr`=1 persisting until reset. Without it, back to FETCH after DECODE.
